seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Runtime-programmable serial pattern detector, successor to the fixed 4-bit detector.
- Pattern length is set by parameter; pattern and overlap mode load at run time.
- Adds an input-valid qualifier, a saturating match counter and an overflow flag.
- Sits on a 1-bit serial stream (UART/line-decode side) and raises a one-cycle pulse per detected pattern.

Parameters:
SEQ_LEN, 4, pattern length in bits (2..32).
DEFAULT_SEQ, 4'b1101, pattern after reset; width SEQ_LEN; bit SEQ_LEN-1 is the first bit received.
DEFAULT_OVERLAP, 1, overlap mode after reset (1 = overlapping matches allowed).
CNT_W, 8, match counter width.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  `in` is sampled only on edges where in_valid=1
cfg_load  input  1  load cfg_seq and cfg_overlap
cfg_seq  input  SEQ_LEN  new pattern, MSB first
cfg_overlap  input  1  new overlap mode
cnt_clr  input  1  clear match_count and cnt_ovf
detected  output  1  one-cycle match pulse (registered)
match_count  output  CNT_W  saturating number of matches
cnt_ovf  output  1  sticky; set when a match occurs with match_count at all-ones

Behaviour:
- Reset (synchronous, highest priority):
  - pattern = DEFAULT_SEQ; overlap = DEFAULT_OVERLAP.
  - window = 0; fill = 0.
  - detected = 0; match_count = 0; cnt_ovf = 0.
- State:
  - window[SEQ_LEN-1:0]: shift register of received bits.
  - fill: 0..SEQ_LEN, counts valid bits in window; saturates at SEQ_LEN.
  - Control FSM states:
    - FILL: fill < SEQ_LEN.
    - ARMED: fill = SEQ_LEN.
    - The MATCH condition is visible only as the detected pulse.
- Sample edge (in_valid=1, cfg_load=0, reset=0):
  - nwin = {window[SEQ_LEN-2:0], in}; nfill = min(fill+1, SEQ_LEN).
  - hit = (nfill == SEQ_LEN) && (nwin == pattern).
  - window <= nwin.
  - If hit and overlap=0: fill <= 0 (FILL state; the next match needs SEQ_LEN fresh bits). Otherwise fill <= nfill.
  - detected <= hit.
- Latency: detected is high in the cycle immediately after the edge that samples the last pattern bit. This is identical to the previous detector's Moore timing.
- Non-sample edge (in_valid=0): window and fill hold; detected <= 0. Gaps in in_valid do not break a partial match.
- detected is never high for two consecutive cycles unless two consecutive sample edges both hit. Example: SEQ_LEN=2, pattern 11, overlap=1, input 1,1,1 gives pulses on the 2nd and 3rd bits.
- Overlap mode: overlap=1 reports every window position that matches; no KMP fallback table is needed because the full window is compared every sample.
- cfg_load=1:
  - pattern <= cfg_seq; overlap <= cfg_overlap; fill <= 0; detected <= 0.
  - in/in_valid are ignored that cycle; match_count is unchanged.
- match_count:
  - Increments by 1 on each hit; saturates at 2^CNT_W-1.
  - A hit while saturated sets cnt_ovf.
- cnt_clr:
  - Clears match_count and cnt_ovf next cycle.
  - If cnt_clr and hit occur on the same edge, clear wins: count = 0, but detected still pulses.
- Priority per edge: reset > cfg_load > sample.
- Reset mid-pattern: the partial match is discarded; the pattern reverts to DEFAULT_SEQ, not to the last loaded value.

Optional Feature:
Macro SEQ_DETECT_MASK_EN.
- Defined:
  - Adds input port cfg_mask [SEQ_LEN-1:0], loaded with cfg_load. Reset value is all ones.
  - Comparison becomes ((nwin ^ pattern) & mask) == 0. Mask bit 0 = don't-care at that position.
  - An all-zero mask matches on every sample once fill = SEQ_LEN.
- Undefined: no cfg_mask port; exact comparison as above.

Test Plan:
- Defaults (SEQ_LEN=4, 1101, overlap=1); stream 1,1,0,1,1,0,1 with in_valid=1 -> detected pulses the cycle after bit 4 and after bit 7; match_count=2.
- cfg_load seq=1101 overlap=0; same stream 1,1,0,1,1,0,1 -> single pulse after bit 4 only (bits 5..7 refill the window; no second match until 4 fresh bits); match_count=1.
- Stream 1,1,0,1 with in_valid low for 3 cycles between bit 2 and bit 3 -> detected pulses after bit 4; no pulse during the gap.
- Reset asserted after bits 1,1,0, then bit 1 -> no pulse; fill restarts from 0.
- CNT_W=2; 4 overlapping matches of pattern 11 (input 1,1,1,1,1) -> match_count saturates at 3, cnt_ovf=1. Then cnt_clr coincident with a hit -> count=0, detected=1.
- With SEQ_DETECT_MASK_EN: seq=1101, mask=1011; input 1,0,0,1 -> detected=1. Input 0,0,0,1 -> no pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with a saturating match counter.
// Optional macro SEQ_DETECT_MASK_EN adds a per-bit compare mask (cfg_mask) loaded with the pattern.
module seq_detect_prog #(
   parameter int                 SEQ_LEN         = 4,
   parameter logic [SEQ_LEN-1:0] DEFAULT_SEQ     = 4'b1101,
   parameter bit                 DEFAULT_OVERLAP = 1'b1,
   parameter int                 CNT_W           = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [SEQ_LEN-1:0] cfg_seq,
   input  logic               cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [SEQ_LEN-1:0] cfg_mask,
`endif
   input  logic               cnt_clr,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               cnt_ovf
);

   localparam int                FILL_W = $clog2(SEQ_LEN + 1);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(SEQ_LEN);

   typedef enum logic {S_FILL, S_ARMED} state_t;

   state_t             state;
   logic [SEQ_LEN-1:0] pattern;
   logic [SEQ_LEN-1:0] mask;
   logic [SEQ_LEN-1:0] window;
   logic [SEQ_LEN-1:0] nwin;
   logic               overlap;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  nfill;
   logic               hit;

   assign nwin  = {window[SEQ_LEN-2:0], in};
   assign nfill = (state == S_ARMED) ? FULL : fill + 1'b1;
   // Full window is compared every sample, so overlapping matches need no fallback table.
   assign hit   = in_valid && !cfg_load && (nfill == FULL) && (((nwin ^ pattern) & mask) == '0);

`ifdef SEQ_DETECT_MASK_EN
   always_ff @(posedge clk) begin
      if (reset)
         mask <= '1;
      else if (cfg_load)
         mask <= cfg_mask;
   end
`else
   assign mask = '1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern  <= DEFAULT_SEQ;
         overlap  <= DEFAULT_OVERLAP;
         window   <= '0;
         fill     <= '0;
         state    <= S_FILL;
         detected <= 1'b0;
      end else if (cfg_load) begin
         pattern  <= cfg_seq;
         overlap  <= cfg_overlap;
         fill     <= '0;
         state    <= S_FILL;
         detected <= 1'b0;
      end else if (in_valid) begin
         window   <= nwin;
         detected <= hit;
         // Non-overlap mode demands SEQ_LEN fresh bits after every match.
         if (hit && !overlap) begin
            fill  <= '0;
            state <= S_FILL;
         end else begin
            fill  <= nfill;
            state <= (nfill == FULL) ? S_ARMED : S_FILL;
         end
      end else begin
         detected <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         match_count <= '0;
         cnt_ovf     <= 1'b0;
      end else if (hit) begin
         if (&match_count)
            cnt_ovf <= 1'b1;
         else
            match_count <= match_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: a 4-bit/8-bit-count instance and a 2-bit/2-bit-count instance
// checked each cycle against a queue-based model, plus directed literal expectations.
module tb_seq_detect_prog;

   localparam int L0 = 4, C0 = 8, L1 = 2, C1 = 2;

   logic clk = 1'b0;
   logic reset = 1'b1, in = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
   logic [3:0] cfg_seq = '0;
`ifdef SEQ_DETECT_MASK_EN
   logic [3:0] cfg_mask = '1;
`endif
   logic          det0, det1, ovf0, ovf1;
   logic [C0-1:0] cnt0;
   logic [C1-1:0] cnt1;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_detect_prog u_dut (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_seq(cfg_seq), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .cnt_clr(cnt_clr), .detected(det0), .match_count(cnt0), .cnt_ovf(ovf0)
   );

   seq_detect_prog #(.SEQ_LEN(L1), .DEFAULT_SEQ(2'b11), .DEFAULT_OVERLAP(1'b1), .CNT_W(C1)) u_small (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_seq(cfg_seq[1:0]), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask(cfg_mask[1:0]),
`endif
      .cnt_clr(cnt_clr), .detected(det1), .match_count(cnt1), .cnt_ovf(ovf1)
   );

   // Model: each queue holds only the bits received since the window last restarted.
   bit         q0[$];
   bit         q1[$];
   logic [3:0] p0 = 4'b1101, m0 = 4'b1111;
   logic [1:0] p1 = 2'b11,   m1 = 2'b11;
   bit         o0 = 1'b1, o1 = 1'b1;
   bit         e_det0 = 1'b0, e_det1 = 1'b0, e_ovf0 = 1'b0, e_ovf1 = 1'b0;
   int         e_cnt0 = 0, e_cnt1 = 0;
   bit         h0, h1;

   function automatic bit qmatch(input bit q[$], input int len, input logic [31:0] pat,
                                 input logic [31:0] msk);
      if (q.size() != len) return 1'b0;
      for (int i = 0; i < len; i++)
         if (msk[len-1-i] && (q[i] != pat[len-1-i])) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cstep(input bit clr, input bit h, input int cw, inout int c, inout bit o);
      if (clr) begin
         c = 0;
         o = 1'b0;
      end else if (h) begin
         if (c == (1 << cw) - 1) o = 1'b1;
         else c = c + 1;
      end
   endtask

   always @(posedge clk) begin
      h0 = 1'b0;
      h1 = 1'b0;
      if (reset) begin
         q0.delete(); q1.delete();
         p0 = 4'b1101; p1 = 2'b11; m0 = '1; m1 = '1; o0 = 1'b1; o1 = 1'b1;
         e_det0 = 1'b0; e_det1 = 1'b0;
      end else if (cfg_load) begin
         q0.delete(); q1.delete();
         p0 = cfg_seq; p1 = cfg_seq[1:0]; o0 = cfg_overlap; o1 = cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
         m0 = cfg_mask; m1 = cfg_mask[1:0];
`endif
         e_det0 = 1'b0; e_det1 = 1'b0;
      end else if (in_valid) begin
         q0.push_back(in);
         if (q0.size() > L0) void'(q0.pop_front());
         h0 = qmatch(q0, L0, 32'(p0), 32'(m0));
         if (h0 && !o0) q0.delete();
         q1.push_back(in);
         if (q1.size() > L1) void'(q1.pop_front());
         h1 = qmatch(q1, L1, 32'(p1), 32'(m1));
         if (h1 && !o1) q1.delete();
         e_det0 = h0; e_det1 = h1;
      end else begin
         e_det0 = 1'b0; e_det1 = 1'b0;
      end
      cstep(reset || cnt_clr, h0, C0, e_cnt0, e_ovf0);
      cstep(reset || cnt_clr, h1, C1, e_cnt1, e_ovf1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model.det0", 32'(det0), 32'(e_det0));
         check("model.cnt0", 32'(cnt0), 32'(e_cnt0));
         check("model.ovf0", 32'(ovf0), 32'(e_ovf0));
         check("model.det1", 32'(det1), 32'(e_det1));
         check("model.cnt1", 32'(cnt1), 32'(e_cnt1));
         check("model.ovf1", 32'(ovf1), 32'(e_ovf1));
      end
   end

   task automatic drive(input bit r, input bit ld, input bit v, input bit b, input bit clr);
      @(negedge clk);
      reset = r; cfg_load = ld; in_valid = v; in = b; cnt_clr = clr;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [3:0] s, input bit o, input logic [3:0] m);
      cfg_seq = s; cfg_overlap = o;
`ifdef SEQ_DETECT_MASK_EN
      cfg_mask = m;
`else
      if (m == 4'hx) $display("unreachable");
`endif
      // in/in_valid are held active to show they are ignored during a load.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   // Sends n bits (bits[n-1] first) and checks det0 against exp after each.
   task automatic run_seq(input string name, input int n, input logic [15:0] bits,
                          input logic [15:0] exp);
      for (int i = n - 1; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, bits[i], 1'b0);
         @(posedge clk); #1;
         check($sformatf("%s.bit%0d", name, n - i), 32'(det0), 32'(exp[i]));
      end
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check("reset.det", 32'(det0), 0);
      check("reset.cnt", 32'(cnt0), 0);
      check("reset.ovf", 32'(ovf0), 0);

      run_seq("ovl", 7, 16'b1101101, 16'b0001001);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovl.count", 32'(cnt0), 2);

      do_reset();
      load(4'b1101, 1'b0, 4'b1111);
      run_seq("novl", 7, 16'b1101101, 16'b0001000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("novl.count", 32'(cnt0), 1);

      do_reset();
      run_seq("gap.a", 2, 16'b11, 16'b00);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         @(posedge clk); #1;
         check("gap.idle", 32'(det0), 0);
      end
      run_seq("gap.b", 2, 16'b01, 16'b01);

      do_reset();
      run_seq("rst.pre", 3, 16'b110, 16'b000);
      do_reset();
      run_seq("rst.post", 4, 16'b1101, 16'b0001);

      load(4'b0000, 1'b1, 4'b1111);
      do_reset();
      run_seq("rst.default", 4, 16'b1101, 16'b0001);

      do_reset();
      run_seq("sat", 5, 16'b11111, 16'b00000);
      check("sat.cnt1", 32'(cnt1), 3);
      check("sat.ovf1", 32'(ovf1), 1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("clrhit.det1", 32'(det1), 1);
      check("clrhit.cnt1", 32'(cnt1), 0);
      check("clrhit.ovf1", 32'(ovf1), 0);

`ifdef SEQ_DETECT_MASK_EN
      do_reset();
      load(4'b1101, 1'b1, 4'b1011);
      run_seq("mask.hit", 4, 16'b1001, 16'b0001);
      do_reset();
      load(4'b1101, 1'b1, 4'b1011);
      run_seq("mask.miss", 4, 16'b0001, 16'b0000);
`endif

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset       = ($urandom_range(0, 499) == 0);
         cfg_load    = ($urandom_range(0, 63) == 0);
         cfg_seq     = 4'($urandom);
         cfg_overlap = 1'($urandom);
`ifdef SEQ_DETECT_MASK_EN
         cfg_mask    = 4'($urandom) | 4'($urandom);
`endif
         cnt_clr     = !cfg_load && ($urandom_range(0, 39) == 0);
         in          = 1'($urandom);
         in_valid    = ($urandom_range(0, 3) != 0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
